// File: rtl/my_nios1_mem_tester_pkg.sv
// Shared types and constants for the on-chip memory tester.
// No logic, so no latency.
// No handshake of its own, so no backpressure.
package my_nios1_mem_tester_pkg;

    // Controller states. FIN may last one or two cycles (see top level).
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_RD    = 3'd2,
        ST_DRAIN = 3'd3,
        ST_FIN   = 3'd4
    } state_t;

    // cfg_op encodings. Code 3 is folded onto OP_BOTH when start is accepted.
    localparam logic [1:0] OP_FILL   = 2'd0;
    localparam logic [1:0] OP_VERIFY = 2'd1;
    localparam logic [1:0] OP_BOTH   = 2'd2;

    localparam int ERR_CNT_W = 16;

    // Saturating increment for the mismatch counter.
    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (v == {ERR_CNT_W{1'b1}}) ? v : v + ERR_CNT_W'(1);
    endfunction

endpackage

// File: rtl/my_nios1_mem_tester_rdpipe.sv
// Tracks outstanding reads: a DEPTH-deep shift register of {valid, word index}.
// An entry pushed on an accepted read appears at the output exactly DEPTH cycles later.
// No backpressure: it shifts every cycle, matching a fixed-latency slave.
module my_nios1_mem_tester_rdpipe #(
    parameter int DEPTH = 1,
    parameter int IDX_W = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [IDX_W-1:0] push_idx,
    output logic             out_vld,
    output logic [IDX_W-1:0] out_idx,
    output logic             empty_nxt
);

    logic [DEPTH-1:0] vld;
    logic [IDX_W-1:0] idx [DEPTH];

    // Shift the valid bits and indices by one stage each cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                idx[k] <= '0;
            end
        end else begin
            vld[0] <= push;
            idx[0] <= push_idx;
            for (int k = 1; k < DEPTH; k++) begin
                vld[k] <= vld[k-1];
                idx[k] <= idx[k-1];
            end
        end
    end

    assign out_vld = vld[DEPTH-1];
    assign out_idx = idx[DEPTH-1];

    // The pipe is empty after this edge if, without a push, nothing remains
    // behind the output stage.
    always_comb begin
        empty_nxt = 1'b1;
        for (int k = 0; k < DEPTH - 1; k++) begin
            if (vld[k]) begin
                empty_nxt = 1'b0;
            end
        end
    end

endmodule

// File: rtl/my_nios1_mem_tester.sv
// Avalon-MM master: fills a word range with seed+i and/or reads it back and compares.
// 1 word/cycle unstalled; an N-word fill gives done N+1 cycles after the start cycle.
// avm_waitrequest holds all request signals unchanged; read data is never stalled.
module my_nios1_mem_tester
    import my_nios1_mem_tester_pkg::*;
#(
    parameter int ADDR_W       = 13,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [1:0]            cfg_op,
    input  logic [ADDR_W-1:0]     cfg_base,
    input  logic [ADDR_W:0]       cfg_words,
    input  logic [DATA_W-1:0]     cfg_seed,
    output logic [ADDR_W-1:0]     avm_address,
    output logic [DATA_W/8-1:0]   avm_byteenable,
    output logic                  avm_read,
    output logic                  avm_write,
    output logic [DATA_W-1:0]     avm_writedata,
    input  logic [DATA_W-1:0]     avm_readdata,
    input  logic                  avm_waitrequest,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_W-1:0]     err_addr,
    output logic [ERR_CNT_W-1:0]  err_count
);

    localparam int IDX_W = ADDR_W + 1;

    state_t              state;
    logic [1:0]          op_q;
    logic [ADDR_W-1:0]   base_q;
    logic [IDX_W-1:0]    words_q;
    logic [DATA_W-1:0]   seed_q;
    logic [IDX_W-1:0]    idx;

    logic                start_acc;
    logic                last_idx;
    logic                rd_push;
    logic                pipe_vld;
    logic [IDX_W-1:0]    pipe_idx;
    logic                pipe_empty_nxt;
    logic                mismatch;

    assign start_acc = (state == ST_IDLE) && start;
    assign last_idx  = (idx == words_q - IDX_W'(1));
    assign rd_push   = avm_read && !avm_waitrequest;

    // Byte lanes are all enabled, but only while a request is being presented.
    assign avm_byteenable = (avm_read || avm_write) ? {(DATA_W/8){1'b1}} : '0;

    my_nios1_mem_tester_rdpipe #(
        .DEPTH (READ_LATENCY),
        .IDX_W (IDX_W)
    ) u_rdpipe (
        .clk       (clk),
        .rst       (reset),
        .push      (rd_push),
        .push_idx  (idx),
        .out_vld   (pipe_vld),
        .out_idx   (pipe_idx),
        .empty_nxt (pipe_empty_nxt)
    );

    // The returning word is checked against the pattern value for its index.
    assign mismatch = pipe_vld && (avm_readdata != (seed_q + DATA_W'(pipe_idx)));

    // Control FSM: it owns the registered bus requests and the status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            op_q          <= OP_FILL;
            base_q        <= '0;
            words_q       <= '0;
            seed_q        <= '0;
            idx           <= '0;
            avm_address   <= '0;
            avm_read      <= 1'b0;
            avm_write     <= 1'b0;
            avm_writedata <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_q          <= (cfg_op == 2'd3) ? OP_BOTH : cfg_op;
                        base_q        <= cfg_base;
                        words_q       <= cfg_words;
                        seed_q        <= cfg_seed;
                        idx           <= '0;
                        avm_address   <= cfg_base;
                        avm_writedata <= cfg_seed;
                        busy          <= 1'b1;
                        pass          <= 1'b0;
                        if (cfg_words == '0) begin
                            state <= ST_FIN;
                        end else if (cfg_op == OP_VERIFY) begin
                            avm_read <= 1'b1;
                            state    <= ST_RD;
                        end else begin
                            avm_write <= 1'b1;
                            state     <= ST_FILL;
                        end
                    end
                end

                ST_FILL: begin
                    if (!avm_waitrequest) begin
                        if (last_idx) begin
                            avm_write   <= 1'b0;
                            idx         <= '0;
                            avm_address <= base_q;
                            if (op_q == OP_FILL) begin
                                // Nothing to compare, so report straight away.
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                pass  <= (err_count == '0);
                                state <= ST_FIN;
                            end else begin
                                avm_read <= 1'b1;
                                state    <= ST_RD;
                            end
                        end else begin
                            idx           <= idx + IDX_W'(1);
                            avm_address   <= avm_address + ADDR_W'(1);
                            avm_writedata <= avm_writedata + DATA_W'(1);
                        end
                    end
                end

                ST_RD: begin
                    if (!avm_waitrequest) begin
                        if (last_idx) begin
                            avm_read <= 1'b0;
                            state    <= ST_DRAIN;
                        end else begin
                            idx         <= idx + IDX_W'(1);
                            avm_address <= avm_address + ADDR_W'(1);
                        end
                    end
                end

                ST_DRAIN: begin
                    // The last compare happens on this same edge.
                    if (pipe_empty_nxt) begin
                        state <= ST_FIN;
                    end
                end

                ST_FIN: begin
                    // Done is raised on entry from FILL; on other paths it is raised
                    // here, once err_count has settled.
                    if (!done) begin
                        done <= 1'b1;
                        busy <= 1'b0;
                        pass <= (err_count == '0);
                    end else begin
                        done  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Count mismatches (saturating) and capture the address of the first one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_count <= '0;
            err_addr  <= '0;
        end else if (start_acc) begin
            err_count <= '0;
            err_addr  <= '0;
        end else if (mismatch) begin
            if (err_count == '0) begin
                err_addr <= base_q + pipe_idx[ADDR_W-1:0];
            end
            err_count <= sat_inc(err_count);
        end
    end

endmodule

// File: tb/tb_my_nios1_mem_tester.sv
// Scoreboard bench: stimulus queues the expected bus accesses and the done
// status, and a negedge monitor pops and compares them as the DUT produces them.
module tb_my_nios1_mem_tester;

    localparam int AW = 13;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [1:0]    cfg_op;
    logic [AW-1:0] cfg_base;
    logic [AW:0]   cfg_words;
    logic [DW-1:0] cfg_seed;
    logic [AW-1:0] avm_address;
    logic [3:0]    avm_byteenable;
    logic          avm_read;
    logic          avm_write;
    logic [DW-1:0] avm_writedata;
    logic [DW-1:0] avm_readdata;
    logic          avm_waitrequest;
    logic          busy;
    logic          done;
    logic          pass;
    logic [AW-1:0] err_addr;
    logic [15:0]   err_count;

    always #5 clk = ~clk;

    my_nios1_mem_tester #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(1)) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .cfg_op          (cfg_op),
        .cfg_base        (cfg_base),
        .cfg_words       (cfg_words),
        .cfg_seed        (cfg_seed),
        .avm_address     (avm_address),
        .avm_byteenable  (avm_byteenable),
        .avm_read        (avm_read),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .err_addr        (err_addr),
        .err_count       (err_count)
    );

    typedef struct {
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } acc_t;

    typedef struct {
        bit            pass;
        logic [15:0]   cnt;
        logic [AW-1:0] eaddr;
        int            lat;
        int            start_cyc;
    } dn_t;

    acc_t exp_acc[$];
    dn_t  exp_dn[$];

    int   total = 0;
    int   bad = 0;
    int   done_cnt = 0;
    int   cyc = 0;
    bit   stall_en = 0;
    bit   flip_en = 0;
    bit   ign_acc = 0;
    logic [AW-1:0] flip_addr = '0;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    logic          prev_stall = 0;
    logic          prev_rd, prev_wr;
    logic [AW-1:0] prev_addr;
    logic [DW-1:0] prev_wd;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Single-port RAM slave, read latency 1, optional single-bit corruption on read.
    always @(posedge clk) begin
        if (avm_write && !avm_waitrequest)
            mem[avm_address] <= avm_writedata;
        if (avm_read && !avm_waitrequest)
            avm_readdata <= mem[avm_address] ^ ((flip_en && avm_address == flip_addr) ? 32'h1 : 32'h0);
    end

    // Random stall, changed just after each edge so it is stable at the next one.
    always @(posedge clk) begin
        #1;
        avm_waitrequest = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    // Monitor: stall stability, accepted accesses, and done status.
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_hold", {avm_read, avm_write, avm_address, avm_writedata},
                    {prev_rd, prev_wr, prev_addr, prev_wd});
            end
            prev_stall = (avm_read || avm_write) && avm_waitrequest;
            prev_rd    = avm_read;
            prev_wr    = avm_write;
            prev_addr  = avm_address;
            prev_wd    = avm_writedata;

            if ((avm_read || avm_write) && !avm_waitrequest && !ign_acc) begin
                chk("rd_wr_excl", {63'd0, avm_read && avm_write}, 64'd0);
                chk("byteenable", {60'd0, avm_byteenable}, 64'hF);
                if (exp_acc.size() == 0) begin
                    chk("extra_access", 64'd1, 64'd0);
                end else begin
                    acc_t a;
                    a = exp_acc.pop_front();
                    chk("acc_kind", {63'd0, avm_write}, {63'd0, a.wr});
                    chk("acc_addr", {51'd0, avm_address}, {51'd0, a.addr});
                    if (a.wr) chk("acc_wdata", {32'd0, avm_writedata}, {32'd0, a.data});
                end
            end

            if (done) begin
                done_cnt++;
                if (exp_dn.size() == 0) begin
                    chk("unexpected_done", 64'd1, 64'd0);
                end else begin
                    dn_t d;
                    d = exp_dn.pop_front();
                    chk("pass", {63'd0, pass}, {63'd0, d.pass});
                    chk("err_count", {48'd0, err_count}, {48'd0, d.cnt});
                    chk("err_addr", {51'd0, err_addr}, {51'd0, d.eaddr});
                    chk("busy_at_done", {63'd0, busy}, 64'd0);
                    if (d.lat >= 0) chk("done_latency", 64'(cyc - d.start_cyc), 64'(d.lat));
                end
            end
        end
    end

    // Queue the expected accesses and result, pulse start, then wait for done.
    task automatic run_op(input logic [1:0] op, input logic [AW-1:0] base, input int words,
                          input logic [DW-1:0] seed, input bit xp, input logic [15:0] xc,
                          input logic [AW-1:0] xa, input int lat);
        int  n0;
        bit  seen;
        dn_t d;
        acc_t a;
        if (op != 2'd1) begin
            for (int i = 0; i < words; i++) begin
                a.wr = 1'b1; a.addr = AW'(base + AW'(i)); a.data = seed + DW'(i);
                exp_acc.push_back(a);
            end
        end
        if (op != 2'd0) begin
            for (int i = 0; i < words; i++) begin
                a.wr = 1'b0; a.addr = AW'(base + AW'(i)); a.data = '0;
                exp_acc.push_back(a);
            end
        end
        @(posedge clk); #1;
        d.pass = xp; d.cnt = xc; d.eaddr = xa; d.lat = lat; d.start_cyc = cyc;
        exp_dn.push_back(d);
        n0 = done_cnt;
        cfg_op = op; cfg_base = base; cfg_words = (AW+1)'(words); cfg_seed = seed;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // Scramble the config to show it was latched.
        cfg_op = 2'd1; cfg_base = 13'h0AAA; cfg_words = 14'd3; cfg_seed = 32'h5555_5555;
        seen = 1'b0;
        for (int k = 0; k < 3000 && !seen; k++) begin
            @(posedge clk);
            if (done_cnt > n0) seen = 1'b1;
        end
        chk("done_timeout", {63'd0, seen}, 64'd1);
        chk("leftover_accesses", 64'(exp_acc.size()), 64'd0);
        exp_acc.delete();
        exp_dn.delete();
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
        chk({tag, "_done"}, {63'd0, done}, 64'd0);
        chk({tag, "_pass"}, {63'd0, pass}, 64'd0);
        chk({tag, "_err_count"}, {48'd0, err_count}, 64'd0);
        chk({tag, "_err_addr"}, {51'd0, err_addr}, 64'd0);
        chk({tag, "_req"}, {62'd0, avm_read, avm_write}, 64'd0);
        chk({tag, "_be"}, {60'd0, avm_byteenable}, 64'd0);
    endtask

    initial begin
        int  n0;
        bit  seen;
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        reset = 1'b1; start = 1'b0; cfg_op = '0; cfg_base = '0; cfg_words = '0; cfg_seed = '0;
        avm_waitrequest = 1'b0; avm_readdata = '0;
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        @(posedge clk); #1;
        reset = 1'b0;

        // 1: fill then verify 16 words
        run_op(2'd2, 13'h0000, 16, 32'h0000_1000, 1'b1, 16'd0, '0, -1);
        // 2: fill only, data wraps at 2^32; done 5 cycles after start
        run_op(2'd0, 13'h0032, 4, 32'hFFFF_FFFE, 1'b1, 16'd0, '0, 5);
        // 3: address wraps at the top of memory
        run_op(2'd2, 13'h1FFE, 4, 32'h0000_00A0, 1'b1, 16'd0, '0, -1);
        // 4: fill, then corrupt word 7 on read and verify
        run_op(2'd0, 13'h0000, 10, 32'd5, 1'b1, 16'd0, '0, 11);
        flip_en = 1'b1; flip_addr = 13'd7;
        run_op(2'd1, 13'h0000, 10, 32'd5, 1'b0, 16'd1, 13'd7, -1);
        flip_en = 1'b0;
        // reserved op 3 behaves as fill+verify
        run_op(2'd3, 13'h0400, 3, 32'h0BAD_0000, 1'b1, 16'd0, '0, -1);
        // 5: random stalls on a 64-word fill+verify
        stall_en = 1'b1;
        run_op(2'd2, 13'h00C8, 64, 32'hDEAD_0000, 1'b1, 16'd0, '0, -1);
        stall_en = 1'b0;
        // 6a: zero words -> done 2 cycles after start, no bus access
        run_op(2'd2, 13'h0010, 0, 32'h1, 1'b1, 16'd0, '0, 2);

        // 6b: reset during the read phase aborts without done
        ign_acc = 1'b1;
        @(posedge clk); #1;
        cfg_op = 2'd1; cfg_base = 13'd100; cfg_words = 14'd16; cfg_seed = 32'h7;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clk);
            if (avm_read) seen = 1'b1;
        end
        chk("rd_started", {63'd0, seen}, 64'd1);
        repeat (3) @(posedge clk);
        #1;
        n0 = done_cnt;
        reset = 1'b1;
        @(negedge clk);
        chk_idle_outputs("midrd_reset");
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("no_done_after_abort", 64'(done_cnt - n0), 64'd0);
        chk_idle_outputs("post_abort");
        ign_acc = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
